// File: rtl/vga_sync_rx_if.sv
// Sync inputs and recovered timing/pixel outputs of the VGA sync receiver.
interface vga_sync_rx_if #(
  parameter int H_W = 11,
  parameter int V_W = 10,
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           hsync;
  logic           vsync;
  logic           activevideo;
  logic [H_W-1:0] h_total;
  logic [V_W-1:0] v_total;
  logic [H_W-1:0] h_active;
  logic [V_W-1:0] v_active;
  logic [X_W-1:0] x_px;
  logic [Y_W-1:0] y_px;
  logic           pix_valid;
  logic           locked;
  logic           err;

  modport master (
    output hsync, vsync, activevideo,
    input  h_total, v_total, h_active, v_active, x_px, y_px, pix_valid, locked, err
  );

  modport slave (
    input  hsync, vsync, activevideo,
    output h_total, v_total, h_active, v_active, x_px, y_px, pix_valid, locked, err
  );
endinterface

// File: rtl/vga_sync_rx.sv
// Measures incoming VGA sync timing, locks once frames repeat, and recovers active pixel coordinates.
// Measurements update at sync edges; pixel coordinates follow the input with one clock of latency.
module vga_sync_rx #(
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_sync_rx_if.slave bus
);
  localparam int M_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [V_W-1:0] V_MAX = '1;
  localparam logic [H_W-1:0] X_LIM = H_W'((1 << X_W) - 1);
  localparam logic [V_W-1:0] Y_LIM = V_W'((1 << Y_W) - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
  state_t state;

  logic           hs_q, vs_q, de_q, line_act;
  logic [H_W-1:0] h_cnt, de_cnt, ref_h, h_new;
  logic [V_W-1:0] v_cnt, va_cnt, ref_v, v_new;
  logic [M_W-1:0] match_cnt, match_nxt;
  logic           hfall, vfall, defall, h_sat, h_bad, v_bad, pix;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;

  always_comb begin
    hfall     = hs_q & ~bus.hsync;
    vfall     = vs_q & ~bus.vsync;
    defall    = de_q & ~bus.activevideo;
    // A saturated line counter means hsync has gone missing.
    h_sat     = (h_cnt == H_MAX) & ~hfall;
    h_new     = hfall ? h_cnt + H_W'(1) : bus.h_total;
    v_new     = v_cnt + V_W'(hfall);
    h_bad     = hfall & (h_new != ref_h);
    v_bad     = vfall & (v_new != ref_v);
    match_nxt = ((h_new == ref_h) && (v_new == ref_v)) ? match_cnt + M_W'(1) : '0;
    pix       = (state == LOCKED) & bus.activevideo;
    x_nxt     = (de_cnt > X_LIM) ? '1 : X_W'(de_cnt);
    y_nxt     = (va_cnt > Y_LIM) ? '1 : Y_W'(va_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      de_q          <= 1'b0;
      line_act      <= 1'b0;
      h_cnt         <= '0;
      de_cnt        <= '0;
      v_cnt         <= '0;
      va_cnt        <= '0;
      ref_h         <= '0;
      ref_v         <= '0;
      match_cnt     <= '0;
      state         <= SEARCH;
      bus.h_total   <= '0;
      bus.v_total   <= '0;
      bus.h_active  <= '0;
      bus.v_active  <= '0;
      bus.x_px      <= '0;
      bus.y_px      <= '0;
      bus.pix_valid <= 1'b0;
      bus.locked    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      hs_q <= bus.hsync;
      vs_q <= bus.vsync;
      de_q <= bus.activevideo;

      if (hfall) begin
        h_cnt       <= '0;
        bus.h_total <= h_new;
      end else if (h_cnt != H_MAX) begin
        h_cnt <= h_cnt + H_W'(1);
      end

      if (hfall)
        de_cnt <= '0;
      else if (bus.activevideo && de_cnt != H_MAX)
        de_cnt <= de_cnt + H_W'(1);
      // Sampled before the hfall clear when both edges coincide.
      if (defall)
        bus.h_active <= de_cnt;

      line_act <= ~hfall & (line_act | bus.activevideo);

      if (vfall) begin
        v_cnt        <= '0;
        va_cnt       <= '0;
        bus.v_total  <= v_new;
        bus.v_active <= va_cnt;
      end else if (hfall) begin
        v_cnt <= v_cnt + V_W'(1);
        if (line_act && va_cnt != V_MAX)
          va_cnt <= va_cnt + V_W'(1);
      end

      // va_cnt is the number of completed active lines, i.e. the current row index.
      bus.pix_valid <= pix;
      bus.x_px      <= pix ? x_nxt : '0;
      bus.y_px      <= pix ? y_nxt : '0;
      bus.err       <= 1'b0;

      case (state)
        SEARCH: begin
          if (vfall) begin
            ref_h     <= h_new;
            ref_v     <= v_new;
            match_cnt <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (h_sat) begin
            state <= SEARCH;
          end else if (vfall) begin
            ref_h     <= h_new;
            ref_v     <= v_new;
            match_cnt <= match_nxt;
            if (match_nxt == M_W'(LOCK_FRAMES)) begin
              state      <= LOCKED;
              bus.locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (h_sat || h_bad || v_bad) begin
            bus.err    <= 1'b1;
            bus.locked <= 1'b0;
            state      <= SEARCH;
          end
        end
        default: begin
          state      <= SEARCH;
          bus.locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_sync_rx.sv
// Drives scaled-down random VGA modes into vga_sync_rx and compares every output, every cycle,
// against an event-level reference model; also checks frame-level totals derived from the mode.
module tb_vga_sync_rx;
  localparam int LOCK_FRAMES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sync_rx_if bus ();

  vga_sync_rx #(
    .H_W(11), .V_W(10), .X_W(10), .Y_W(10), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Current mode: line/frame geometry in clocks and lines.
  int htot, hs0, hsl, ha0, vtot, vs0, vsl, va0, val;

  // Reference model state.
  int ecount = 0;
  int last_h, act_line, lines, act_lines;
  bit had_act, hs_p, vs_p, de_p, m_locked;
  int e_htot, e_vtot, e_hact, e_vact, e_x, e_y;
  bit e_pv, e_err;
  int ref_h, ref_v;
  int unsigned meas_q[$];

  // Observation statistics.
  int n_err, n_pv, first_x, first_y, last_x, last_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecount);
    end
  endtask

  task automatic model_edge(input bit hs, input bit vs, input bit de, input bit r);
    bit hf, vf, df, sat, all_same;
    int hc, new_h, new_v;
    int unsigned key;
    if (r) begin
      last_h = ecount; act_line = 0; had_act = 0; lines = 0; act_lines = 0;
      e_htot = 0; e_vtot = 0; e_hact = 0; e_vact = 0; e_x = 0; e_y = 0;
      e_pv = 0; e_err = 0; m_locked = 0; meas_q.delete();
      hs_p = 1; vs_p = 1; de_p = 0;
      return;
    end
    hf = hs_p && !hs;
    vf = vs_p && !vs;
    df = de_p && !de;
    hc = ecount - last_h - 1;
    if (hc > 2047) hc = 2047;
    new_h = hf ? (hc + 1) % 2048 : e_htot;
    new_v = (lines + (hf ? 1 : 0)) % 1024;
    sat = !hf && (hc == 2047);

    e_pv  = m_locked && de;
    e_x   = e_pv ? ((act_line > 1023) ? 1023 : act_line) : 0;
    e_y   = e_pv ? ((act_lines > 1023) ? 1023 : act_lines) : 0;
    e_err = 0;
    if (df) e_hact = act_line;
    if (hf) e_htot = new_h;
    if (vf) begin
      e_vtot = new_v;
      e_vact = act_lines;
    end

    // Lock once the last LOCK_FRAMES+1 frame measurements since losing lock are identical.
    key = unsigned'(new_h) * 65536 + unsigned'(new_v);
    if (m_locked) begin
      if ((hf && new_h != ref_h) || (vf && new_v != ref_v) || sat) begin
        e_err = 1;
        m_locked = 0;
        meas_q.delete();
      end
    end else if (sat && meas_q.size() > 0) begin
      meas_q.delete();
    end else if (vf) begin
      meas_q.push_back(key);
      if (meas_q.size() >= LOCK_FRAMES + 1) begin
        all_same = 1;
        for (int i = meas_q.size() - LOCK_FRAMES - 1; i < meas_q.size(); i++)
          if (meas_q[i] != key) all_same = 0;
        if (all_same) begin
          m_locked = 1;
          ref_h = new_h;
          ref_v = new_v;
        end
      end
    end

    if (hf) begin
      last_h = ecount;
      act_line = 0;
    end else if (de && act_line < 2047) begin
      act_line++;
    end
    if (vf) begin
      lines = 0;
      act_lines = 0;
    end else if (hf) begin
      lines = (lines + 1) % 1024;
      if (had_act && act_lines < 1023) act_lines++;
    end
    had_act = hf ? 0 : (had_act | de);
    hs_p = hs; vs_p = vs; de_p = de;
  endtask

  task automatic step(input bit hs, input bit vs, input bit de, input bit r);
    bus.hsync = hs;
    bus.vsync = vs;
    bus.activevideo = de;
    rst = r;
    ecount++;
    model_edge(hs, vs, de, r);
    @(posedge clk);
    #1;
    chk("h_total", 32'(bus.h_total), e_htot);
    chk("v_total", 32'(bus.v_total), e_vtot);
    chk("h_active", 32'(bus.h_active), e_hact);
    chk("v_active", 32'(bus.v_active), e_vact);
    chk("x_px", 32'(bus.x_px), e_x);
    chk("y_px", 32'(bus.y_px), 32'(e_y));
    chk("pix_valid", 32'(bus.pix_valid), 32'(e_pv));
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("err", 32'(bus.err), 32'(e_err));
    if (bus.err === 1'b1) n_err++;
    if (bus.pix_valid === 1'b1) begin
      if (n_pv == 0) begin
        first_x = int'(bus.x_px);
        first_y = int'(bus.y_px);
      end
      n_pv++;
      last_x = int'(bus.x_px);
      last_y = int'(bus.y_px);
    end
  endtask

  task automatic pick_mode();
    htot = $urandom_range(90, 48);
    hs0  = $urandom_range(6, 2);
    hsl  = $urandom_range(8, 3);
    ha0  = hs0 + hsl + $urandom_range(6, 2);
    vtot = $urandom_range(18, 12);
    vs0  = $urandom_range(2, 1);
    vsl  = $urandom_range(3, 1);
    va0  = vs0 + vsl + $urandom_range(2, 1);
    val  = vtot - va0 - 1 - $urandom_range(1, 0);
  endtask

  // coinc moves the vsync fall onto the hsync fall of line vs0.
  task automatic run_frames(input int nfr, input int start_line, input int short_line, input bit coinc);
    n_err = 0;
    n_pv = 0;
    for (int f = 0; f < nfr; f++) begin
      for (int l = (f == 0) ? start_line : 0; l < vtot; l++) begin
        int len;
        len = (f == 0 && l == short_line) ? htot - 1 : htot;
        for (int hc = 0; hc < len; hc++) begin
          bit hs, vs, de;
          hs = !(hc >= hs0 && hc < hs0 + hsl);
          if (coinc)
            vs = !((l == vs0 && hc >= hs0) || (l > vs0 && l < vs0 + vsl) || (l == vs0 + vsl && hc < hs0));
          else
            vs = !(l >= vs0 && l < vs0 + vsl);
          de = (l >= va0) && (l < va0 + val) && (hc >= ha0);
          step(hs, vs, de, 1'b0);
        end
      end
    end
  endtask

  task automatic check_mode_totals(input string tag);
    chk({tag, "_h_total"}, 32'(bus.h_total), htot);
    chk({tag, "_v_total"}, 32'(bus.v_total), vtot);
    chk({tag, "_h_active"}, 32'(bus.h_active), htot - ha0);
    chk({tag, "_v_active"}, 32'(bus.v_active), val);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.activevideo = 1'b0;
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    chk("reset_locked", 32'(bus.locked), 0);
    chk("reset_h_total", 32'(bus.h_total), 0);

    // Start mid-frame: the first vfall measures a partial frame, lock follows the 4th vfall.
    pick_mode();
    run_frames(4, vtot / 2, -1, 0);
    chk("lock_before_4th_vfall", 32'(bus.locked), 0);
    run_frames(1, 0, -1, 0);
    chk("lock_after_4th_vfall", 32'(bus.locked), 1);
    check_mode_totals("nominal");

    run_frames(2, 0, -1, 0);
    chk("pix_count", n_pv, 2 * val * (htot - ha0));
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("last_x", last_x, htot - ha0 - 1);
    chk("last_y", last_y, val - 1);
    chk("no_err_locked", n_err, 0);

    // One short line while locked.
    run_frames(1, 0, va0 + 1, 0);
    chk("short_err_pulses", n_err, 1);
    chk("short_unlocked", 32'(bus.locked), 0);
    run_frames(2, 0, -1, 0);
    chk("relock_not_yet", 32'(bus.locked), 0);
    run_frames(1, 0, -1, 0);
    chk("relock_3rd_vfall", 32'(bus.locked), 1);

    // hsync stuck high long enough to saturate the line counter.
    n_err = 0;
    repeat (2100) step(1, 1, 0, 0);
    chk("stuck_err_pulses", n_err, 1);
    chk("stuck_unlocked", 32'(bus.locked), 0);
    run_frames(5, 0, -1, 0);
    chk("stuck_relock", 32'(bus.locked), 1);

    // Single-cycle reset while locked.
    step(1, 1, 0, 1);
    chk("midrst_locked", 32'(bus.locked), 0);
    chk("midrst_v_total", 32'(bus.v_total), 0);
    chk("midrst_pix_valid", 32'(bus.pix_valid), 0);
    run_frames(4, 0, -1, 0);
    chk("midrst_relock", 32'(bus.locked), 1);

    // vsync and hsync falling together.
    run_frames(4, 0, -1, 1);
    chk("coinc_locked", 32'(bus.locked), 1);
    check_mode_totals("coinc");

    for (int k = 0; k < 2; k++) begin
      pick_mode();
      step(1, 1, 0, 1);
      run_frames(5, vtot / 2, -1, 0);
      chk("rand_locked", 32'(bus.locked), 1);
      check_mode_totals("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end
endmodule
